// File: rtl/jt12_mixacc.sv
`default_nettype none
// ============================================================================
// Module   : jt12_mixacc
// Brief    : FM operator accumulator and stereo mixer; optional saturation
//            limiter built when JT12_ACC_LIMIT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module jt12_mixacc #(
    parameter int CH   = 6,
    parameter int OPW  = 9,
    parameter int MIXW = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clk_en,
    input  logic                             frame_start,
    input  logic signed [OPW-1:0]            op_result,
    input  logic        [2:0]                alg,
    input  logic        [1:0]                rl,
    input  logic                             limiter_en,
    input  logic                             pcm_en,
    input  logic        [OPW-1:0]            pcm,
    output logic signed [MIXW-1:0]           left,
    output logic signed [MIXW-1:0]           right,
    output logic                             sample,
    output logic signed [OPW-1:0]            mux_out,
    output logic        [$clog2(CH)-1:0]     mux_ch,
    output logic                             mux_left,
    output logic                             mux_right,
    output logic                             mux_valid
);

    localparam int              CHW     = $clog2(CH);
    localparam logic [CHW-1:0]  LAST_CH = CHW'(CH - 1);

    logic        [CHW-1:0]  r_ch;
    logic        [1:0]      r_op;
    logic signed [OPW-1:0]  r_acc [CH];
    logic signed [MIXW-1:0] r_mix_l;
    logic signed [MIXW-1:0] r_mix_r;
    logic                   r_frame_ok;

    logic        [CHW-1:0]  w_cur_ch;
    logic        [1:0]      w_cur_op;
    logic                   w_last_ch;
    logic                   w_op3;
    logic                   w_last;
    logic                   w_truncate;
    logic                   w_carrier;
    logic signed [OPW-1:0]  w_acc_cur;
    logic signed [OPW:0]    w_sum;
    logic signed [OPW-1:0]  w_sum_lim;
    logic signed [OPW-1:0]  w_acc_next;
    logic signed [OPW-1:0]  w_total;
    logic signed [MIXW-1:0] w_total_ext;
    logic signed [MIXW-1:0] w_mix_l_next;
    logic signed [MIXW-1:0] w_mix_r_next;

    // frame_start forces the current input to slot 0 (op 0, ch 0)
    assign w_cur_ch   = frame_start ? '0 : r_ch;
    assign w_cur_op   = frame_start ? 2'd0 : r_op;
    assign w_last_ch  = (w_cur_ch == LAST_CH);
    assign w_op3      = (w_cur_op == 2'd3);
    assign w_last     = w_op3 && w_last_ch;
    assign w_truncate = frame_start && ((r_ch != '0) || (r_op != 2'd0));

    always_comb begin
        w_carrier = 1'b0;
        case (w_cur_op)
            2'd0:    w_carrier = (alg == 3'd7);
            2'd1:    w_carrier = (alg >= 3'd4);
            2'd2:    w_carrier = (alg >= 3'd5);
            default: w_carrier = 1'b1;
        endcase
    end

    assign w_acc_cur = r_acc[w_cur_ch];
    assign w_sum     = {w_acc_cur[OPW-1], w_acc_cur} + {op_result[OPW-1], op_result};

`ifdef JT12_ACC_LIMIT_EN
    logic w_ovf;
    assign w_ovf = w_sum[OPW] ^ w_sum[OPW-1];
    always_comb begin
        w_sum_lim = w_sum[OPW-1:0];
        if (limiter_en && w_ovf)
            w_sum_lim = w_sum[OPW] ? {1'b1, {(OPW-1){1'b0}}} : {1'b0, {(OPW-1){1'b1}}};
    end
`else
    logic [1:0] w_unused_bits;
    assign w_unused_bits = {limiter_en, w_sum[OPW]};
    assign w_sum_lim     = w_sum[OPW-1:0];
`endif

    always_comb begin
        w_acc_next = w_acc_cur;
        if (w_cur_op == 2'd0)
            w_acc_next = w_carrier ? op_result : '0;
        else if (w_carrier)
            w_acc_next = w_sum_lim;
    end

    // PCM is offset-binary: flipping the MSB yields two's complement
    assign w_total      = (pcm_en && w_last_ch) ? {~pcm[OPW-1], pcm[OPW-2:0]} : w_acc_next;
    assign w_total_ext  = {{(MIXW-OPW){w_total[OPW-1]}}, w_total};
    assign w_mix_l_next = (rl[1] ? w_total_ext : '0) + ((w_cur_ch == '0) ? '0 : r_mix_l);
    assign w_mix_r_next = (rl[0] ? w_total_ext : '0) + ((w_cur_ch == '0) ? '0 : r_mix_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch       <= '0;
            r_op       <= 2'd0;
            for (int i = 0; i < CH; i++) r_acc[i] <= '0;
            r_mix_l    <= '0;
            r_mix_r    <= '0;
            r_frame_ok <= 1'b1;
            left       <= '0;
            right      <= '0;
            sample     <= 1'b0;
            mux_out    <= '0;
            mux_ch     <= '0;
            mux_left   <= 1'b0;
            mux_right  <= 1'b0;
            mux_valid  <= 1'b0;
        end else if (clk_en) begin
            if (w_last_ch) begin
                r_ch <= '0;
                r_op <= w_cur_op + 2'd1;
            end else begin
                r_ch <= w_cur_ch + CHW'(1);
                r_op <= w_cur_op;
            end
            r_acc[w_cur_ch] <= w_acc_next;
            mux_valid       <= w_op3;
            sample          <= 1'b0;
            if (w_truncate)
                r_frame_ok <= 1'b0;
            if (w_op3) begin
                mux_out   <= w_total;
                mux_ch    <= w_cur_ch;
                mux_left  <= rl[1];
                mux_right <= rl[0];
                r_mix_l   <= w_mix_l_next;
                r_mix_r   <= w_mix_r_next;
                // A mix restarted at ch 0 is a consistent frame again
                if (w_cur_ch == '0)
                    r_frame_ok <= 1'b1;
            end
            if (w_last && r_frame_ok) begin
                left   <= w_mix_l_next;
                right  <= w_mix_r_next;
                sample <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jt12_mixacc.sv
`default_nettype none
// ============================================================================
// Module   : tb_jt12_mixacc
// Brief    : Self-checking bench for jt12_mixacc (directed table + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jt12_mixacc;

    localparam int CH   = 6;
    localparam int OPW  = 9;
    localparam int MIXW = 12;
    localparam int CHW  = $clog2(CH);
`ifdef JT12_ACC_LIMIT_EN
    localparam bit LIM_BUILT = 1'b1;
`else
    localparam bit LIM_BUILT = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst, clk_en, frame_start, limiter_en, pcm_en;
    logic signed [OPW-1:0]  op_result;
    logic        [2:0]      alg;
    logic        [1:0]      rl;
    logic        [OPW-1:0]  pcm;
    logic signed [MIXW-1:0] left, right;
    logic                   sample;
    logic signed [OPW-1:0]  mux_out;
    logic        [CHW-1:0]  mux_ch;
    logic                   mux_left, mux_right, mux_valid;

    jt12_mixacc #(.CH(CH), .OPW(OPW), .MIXW(MIXW)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .frame_start(frame_start),
        .op_result(op_result), .alg(alg), .rl(rl), .limiter_en(limiter_en),
        .pcm_en(pcm_en), .pcm(pcm), .left(left), .right(right), .sample(sample),
        .mux_out(mux_out), .mux_ch(mux_ch), .mux_left(mux_left),
        .mux_right(mux_right), .mux_valid(mux_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        int ch; int v0; int v1; int v2; int v3; int alg; int rl;
        int pcm_en; int pcm; int lim; int e_tot; int e_l; int e_r;
    } vec_t;

    vec_t tbl[9];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   gaps  = 1'b0;
    int   f_ops[4][CH];
    int   f_alg[CH];
    int   f_rl[CH];
    bit   f_pcm_en, f_lim;
    int   f_pcm;
    int   et[CH];
    int   el, er, last_l, last_r;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int wrapw(input int x);
        int r;
        r = x & ((1 << OPW) - 1);
        if (r >= (1 << (OPW - 1))) r -= (1 << OPW);
        return r;
    endfunction

    function automatic int clampw(input int x);
        if (x > (1 << (OPW - 1)) - 1) return (1 << (OPW - 1)) - 1;
        if (x < -(1 << (OPW - 1)))    return -(1 << (OPW - 1));
        return x;
    endfunction

    function automatic bit is_carrier(input int a, input int op);
        return (op == 3) || (op == 2 && a >= 5) || (op == 1 && a >= 4) || (op == 0 && a == 7);
    endfunction

    // Reference: per-channel sum of carriers, then pan-gated stereo sums
    task automatic model(output int tot[CH], output int l, output int r);
        int acc;
        bit lim_on;
        lim_on = LIM_BUILT && f_lim;
        l = 0;
        r = 0;
        for (int c = 0; c < CH; c++) begin
            acc = 0;
            for (int op = 0; op < 4; op++) begin
                if (op == 0)
                    acc = is_carrier(f_alg[c], 0) ? f_ops[0][c] : 0;
                else if (is_carrier(f_alg[c], op))
                    acc = lim_on ? clampw(acc + f_ops[op][c]) : wrapw(acc + f_ops[op][c]);
            end
            if (f_pcm_en && c == CH - 1) acc = f_pcm - (1 << (OPW - 1));
            tot[c] = acc;
            if ((f_rl[c] & 2) != 0) l += acc;
            if ((f_rl[c] & 1) != 0) r += acc;
        end
    endtask

    task automatic drive(input bit fs, input int opv, input int a, input int r);
        if (gaps && $urandom_range(0, 3) == 0) begin
            clk_en      = 1'b0;
            frame_start = 1'($urandom_range(0, 1));
            op_result   = OPW'($urandom);
            @(posedge clk); #1;
        end
        clk_en      = 1'b1;
        frame_start = fs;
        op_result   = OPW'(opv);
        alg         = 3'(a);
        rl          = 2'(r);
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input bit fs0, input int exp_tot[CH], input int exp_l,
                             input int exp_r, input string tag);
        limiter_en = f_lim;
        pcm_en     = f_pcm_en;
        pcm        = OPW'(f_pcm);
        for (int op = 0; op < 4; op++) begin
            for (int c = 0; c < CH; c++) begin
                drive((op == 0 && c == 0) ? fs0 : 1'b0, f_ops[op][c], f_alg[c], f_rl[c]);
                check($sformatf("%s.valid[%0d.%0d]", tag, op, c), int'(mux_valid), (op == 3) ? 1 : 0);
                if (op == 3) begin
                    check($sformatf("%s.mux_out[%0d]", tag, c), int'(mux_out), exp_tot[c]);
                    check($sformatf("%s.mux_ch[%0d]", tag, c), int'(mux_ch), c);
                    check($sformatf("%s.mux_lr[%0d]", tag, c), int'({mux_left, mux_right}), f_rl[c]);
                end
                if (op == 3 && c == CH - 1) begin
                    check($sformatf("%s.sample", tag), int'(sample), 1);
                    check($sformatf("%s.left", tag), int'(left), exp_l);
                    check($sformatf("%s.right", tag), int'(right), exp_r);
                end else begin
                    check($sformatf("%s.nosample[%0d.%0d]", tag, op, c), int'(sample), 0);
                end
            end
        end
        last_l = exp_l;
        last_r = exp_r;
    endtask

    task automatic run_partial(input int n, input string tag);
        for (int s = 0; s < n; s++) begin
            drive(s == 0, int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 3)));
            check($sformatf("%s.nosample[%0d]", tag, s), int'(sample), 0);
        end
        check($sformatf("%s.left_hold", tag), int'(left), last_l);
        check($sformatf("%s.right_hold", tag), int'(right), last_r);
    endtask

    task automatic clear_frame();
        for (int c = 0; c < CH; c++) begin
            for (int op = 0; op < 4; op++) f_ops[op][c] = 0;
            f_alg[c] = 7;
            f_rl[c]  = 3;
        end
        f_pcm_en = 1'b0;
        f_pcm    = 0;
        f_lim    = 1'b0;
    endtask

    task automatic random_frame();
        for (int c = 0; c < CH; c++) begin
            for (int op = 0; op < 4; op++) f_ops[op][c] = int'($urandom_range(0, 511)) - 256;
            f_alg[c] = int'($urandom_range(0, 7));
            f_rl[c]  = int'($urandom_range(0, 3));
        end
        f_pcm_en = 1'($urandom_range(0, 1));
        f_pcm    = int'($urandom_range(0, 511));
        f_lim    = 1'($urandom_range(0, 1));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".left"}, int'(left), 0);
        check({tag, ".right"}, int'(right), 0);
        check({tag, ".sample"}, int'(sample), 0);
        check({tag, ".mux_out"}, int'(mux_out), 0);
        check({tag, ".mux_ch"}, int'(mux_ch), 0);
        check({tag, ".mux_lr"}, int'({mux_left, mux_right}), 0);
        check({tag, ".mux_valid"}, int'(mux_valid), 0);
    endtask

    initial begin
        int e_big, e_neg;
        e_big = LIM_BUILT ? 255 : -224;
        e_neg = LIM_BUILT ? -256 : 224;
        //          ch  v0    v1    v2    v3   alg rl pcm_en pcm lim  tot    l      r
        tbl[0] = '{0,   10,   10,   10,   10,  7,  3, 0,     0,  0,   40,    40,    40};
        tbl[1] = '{0,   200,  200,  200,  200, 7,  3, 0,     0,  1,   e_big, e_big, e_big};
        tbl[2] = '{2,   100,  100,  100,  5,   0,  3, 0,     0,  0,   5,     5,     5};
        tbl[3] = '{2,   100,  100,  100,  5,   4,  3, 0,     0,  0,   105,   105,   105};
        tbl[4] = '{5,   0,    0,    0,    0,   7,  2, 1,     0,  0,   -256,  -256,  0};
        tbl[5] = '{3,   1,    2,    3,    4,   5,  1, 0,     0,  0,   9,     0,     9};
        tbl[6] = '{1,   -200, -200, -200, -200,7,  3, 0,     0,  1,   e_neg, e_neg, e_neg};
        tbl[7] = '{4,   50,   -60,  70,   -80, 6,  0, 0,     0,  0,   -70,   0,     0};
        tbl[8] = '{0,   7,    7,    7,    -3,  2,  2, 0,     0,  0,   -3,    -3,    0};

        rst = 1'b1; clk_en = 1'b1; frame_start = 1'b0; op_result = '0; alg = '0;
        rl = '0; limiter_en = 1'b0; pcm_en = 1'b0; pcm = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        last_l = 0;
        last_r = 0;

        for (int i = 0; i < 9; i++) begin
            clear_frame();
            f_ops[0][tbl[i].ch] = tbl[i].v0;
            f_ops[1][tbl[i].ch] = tbl[i].v1;
            f_ops[2][tbl[i].ch] = tbl[i].v2;
            f_ops[3][tbl[i].ch] = tbl[i].v3;
            f_alg[tbl[i].ch]    = tbl[i].alg;
            f_rl[tbl[i].ch]     = tbl[i].rl;
            f_pcm_en            = tbl[i].pcm_en != 0;
            f_pcm               = tbl[i].pcm;
            f_lim               = tbl[i].lim != 0;
            for (int c = 0; c < CH; c++) et[c] = 0;
            et[tbl[i].ch] = tbl[i].e_tot;
            run_frame(i[0], et, tbl[i].e_l, tbl[i].e_r, $sformatf("tbl%0d", i));
        end

        clear_frame();
        for (int c = 0; c < CH; c++) begin
            f_ops[0][c] = -256;
            et[c]       = -256;
        end
        run_frame(1'b1, et, -1536, -1536, "allneg");

        random_frame();
        model(et, el, er);
        run_frame(1'b1, et, el, er, "pre_trunc");
        run_partial(10, "trunc10");
        random_frame();
        model(et, el, er);
        run_frame(1'b1, et, el, er, "after_trunc10");
        run_partial(20, "trunc20");
        random_frame();
        model(et, el, er);
        run_frame(1'b1, et, el, er, "after_trunc20");

        run_partial(15, "pre_rst");
        rst = 1'b1; clk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero_outputs("midrst");
        last_l = 0;
        last_r = 0;
        random_frame();
        model(et, el, er);
        run_frame(1'b0, et, el, er, "after_rst");

        gaps = 1'b1;
        for (int k = 0; k < 40; k++) begin
            random_frame();
            model(et, el, er);
            run_frame(1'($urandom_range(0, 1)), et, el, er, $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jt12_mixacc.md
# jt12_mixacc

Parametrised per-channel operator accumulator and stereo mixer for the FM synthesis pipeline. It consumes one operator output per `clk_en` slot in a fixed op-major order, sums each channel's carrier operators per algorithm, and optionally substitutes PCM on the last channel. It emits two outputs:
- a per-channel multiplexed stream;
- a panned, summed stereo frame sample with a `MIXW`-bit range.

## Interface
Parameters:
- `CH`, 6, number of channels (2..16).
- `OPW`, 9, operator/channel result width, signed.
- `MIXW`, 12, stereo mix width; must be ≥ `OPW+$clog2(CH)`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `clk_en` in 1: slot enable; all state advances only when high.
- `frame_start` in 1: marks the current input as slot 0.
- `op_result` in `OPW`: signed operator output for the current slot.
- `alg` in 3: algorithm of the current slot's channel.
- `rl` in 2: pan of the current channel; bit1 = left, bit0 = right.
- `limiter_en` in 1: runtime saturation enable.
- `pcm_en` in 1: PCM replaces channel `CH-1`.
- `pcm` in `OPW`: offset-binary PCM sample.
- `left`, `right` out `MIXW`: signed frame mix.
- `sample` out 1: frame-complete strobe.
- `mux_out` out `OPW`: signed final total of one channel.
- `mux_ch` out `$clog2(CH)`: channel index of `mux_out`.
- `mux_left`, `mux_right` out 1: pan of `mux_out`.
- `mux_valid` out 1: `mux_out` strobe.

## Operation
- Slot counter: `slot` runs 0..`4*CH-1`.
  - `ch = slot % CH`; `op = slot / CH` (op 0..3, meaning S1..S4).
  - On a `clk_en` edge with `frame_start=1`, the input is treated as slot 0. Otherwise `slot` increments and wraps to 0.
- Carrier table:
  - alg 0–3: op3 only.
  - alg 4: op1, op3.
  - alg 5–6: op1, op2, op3.
  - alg 7: all ops.
- Accumulator: register array `acc[CH]` of `OPW` bits.
  - op0: `acc[ch] <= carrier ? op_result : 0`.
  - op1–3, carrier: `acc[ch] <= sum`.
    - Sum is computed at `OPW+1` bits.
    - Saturated to [`-2^(OPW-1)`, `2^(OPW-1)-1`] when limiting is active (see Configuration).
    - Otherwise truncated to `OPW` bits (MSB discarded).
  - op1–3, non-carrier: `acc[ch]` holds.
- Final total, at the op3 slot: the updated accumulator value.
  - If `pcm_en` and `ch==CH-1`, the total is instead `{~pcm[OPW-1], pcm[OPW-2:0]}`, ignoring the operators.
- Per-channel output, on the op3 slot:
  - `mux_out` = total; `mux_ch` = ch; `mux_left`/`mux_right` = `rl`.
  - `mux_valid` = 1 for this slot, 0 on all other slots.
- Mixer: sign-extend the total to `MIXW`; gate each side by `rl`.
  - On ch 0 of op3, `mix_l`/`mix_r` load the contribution. On later channels they accumulate it.
  - On the last slot, `left`/`right` take the final sums and `sample` pulses.
- Partial frame: a `frame_start` arriving at a nonzero slot clears the `frame_ok` flag. The next completed frame (slot 0 through `4*CH-1`) produces `sample`; the truncated frame produces none. `left`/`right` hold their values.

## Timing
- Everything is registered on `posedge clk` when `clk_en=1`.
- `mux_*` are updated at the edge consuming the op3 slot. Latency is 1 `clk_en` edge. Outputs hold until the next op3 slot.
- `left`, `right`, and `sample=1` are updated at the edge consuming slot `4*CH-1`. `sample` stays high until the next `clk_en` edge, then returns to 0.
- `frame_start` and wrap on the same slot: both are consistent, and the frame completes normally.
- Reset clears, on the next clk:
  - `slot`, `acc[*]`, `mix_l`, `mix_r`, and all outputs to 0;
  - `frame_ok` to 1.
  - A reset mid-frame discards the frame; no `sample` is emitted for it.
- `rst` overrides `clk_en`.

## Configuration
- `JT12_ACC_LIMIT_EN` defined: saturation is active when `limiter_en=1`; truncation applies when `limiter_en=0`.
- Undefined: the limiter logic is not built, `limiter_en` is ignored, and all op1–3 sums truncate.

## Test plan
All scenarios use `CH=6`, `OPW=9`, `MIXW=12`.
- alg7, ch0 ops all 10, `rl=11`, other channels 0 → ch0 `mux_out=40`; `left=right=40`; one `sample` per 24 `clk_en`.
- alg7, ch0 ops all 200, `rl=11`:
  - macro defined, `limiter_en=1` → ch0 total 255;
  - macro undefined → ch0 total −224 (wrap path 400→−112→88→−224).
- alg0, ch2 ops 100, 100, 100, 5 → `mux_out=5` with `mux_ch=2`. alg4 with the same ops → 105.
- `pcm_en=1`, `pcm=9'h000`, ch5 `rl=10` → ch5 `mux_out=−256`; left gets −256 and right 0 from ch5.
- All 6 channels at total −256, `rl=11` → `left=right=−1536`, with no overflow.
- `frame_start` asserted at slot 10 → no `sample` for the truncated frame; the next `sample` arrives 24 `clk_en` later. `rst` asserted mid-frame → all outputs 0 and no strobe until a full frame completes.
